// File: rtl/modulus_reconstruct.sv
// Rebuilds Dividend = Quotient*Divisor + Remainder with a one-bit-per-clock
// shift-and-add multiplier, flagging operand pairs no divider could produce.
module modulus_reconstruct #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     Quotient,
    input  logic [WIDTH-1:0]     Divisor,
    input  logic [WIDTH-1:0]     Remainder,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Dividend,
    output logic                 Error
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]          state;
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]    mplier;
    logic [CW-1:0]       count;
    logic [2*WIDTH-1:0]  acc_next;
    logic                bad_operands;

    assign bad_operands = (Divisor == '0) || (Remainder >= Divisor);
    assign acc_next     = mplier[0] ? (acc + mcand) : acc;
    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain acc/mcand updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            Dividend <= '0;
            Error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (bad_operands) begin
                            Dividend <= '0;
                            Error    <= 1'b1;
                            state    <= DONE;
                        end else begin
                            acc    <= {{WIDTH{1'b0}}, Remainder};
                            mcand  <= {{WIDTH{1'b0}}, Divisor};
                            mplier <= Quotient;
                            count  <= '0;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    // Fixed WIDTH-cycle latency: no early exit on zero multiplier.
                    if (count == LAST) begin
                        Dividend <= acc_next;
                        Error    <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modulus_reconstruct.sv
// Self-checking bench for modulus_reconstruct: directed literal cases plus a
// full operand sweep against a transaction-level Q*D+R model with stalls.
module tb_modulus_reconstruct;

    localparam int WIDTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   Quotient = '0;
    logic [3:0]   Divisor = '0;
    logic [3:0]   Remainder = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   Dividend;
    logic         Error;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        int div;
        bit err;
        int acc_cyc;
    } exp_t;

    exp_t model_q[$];
    bit   armed   = 0;
    bit   rst_pend = 0;

    modulus_reconstruct #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Quotient  (Quotient),
        .Divisor   (Divisor),
        .Remainder (Remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Dividend  (Dividend),
        .Error     (Error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit model_err(input int q, input int d, input int r);
        return (d == 0) || (r >= d);
    endfunction

    function automatic int model_div(input int q, input int d, input int r);
        return model_err(q, d, r) ? 0 : q * d + r;
    endfunction

    // Transaction model: one op in flight, result visible 1 (error) or WIDTH+1
    // cycles after acceptance, held until consumed; reset drops it.
    always @(negedge clk) begin : compare
        bit busy;
        bit ov;
        if (rst) begin
            model_q.delete();
            armed    = 1;
            rst_pend = 1;
        end else if (armed) begin
            if (rst_pend) begin
                check("reset_dividend", Dividend, 0);
                check("reset_error", Error, 0);
                rst_pend = 0;
            end
            if (model_q.size() != 0) begin
                busy = 1;
                ov   = (cyc - model_q[0].acc_cyc + 1) >= (model_q[0].err ? 1 : WIDTH + 1);
            end else begin
                busy = 0;
                ov   = 0;
            end
            check("in_ready", in_ready, !busy);
            check("out_valid", out_valid, ov);
            if (ov) begin
                check("model_dividend", Dividend, model_q[0].div);
                check("model_error", Error, model_q[0].err);
                if (out_ready) void'(model_q.pop_front());
            end else if (!busy && in_valid) begin
                model_q.push_back('{div: model_div(Quotient, Divisor, Remainder),
                                    err: model_err(Quotient, Divisor, Remainder),
                                    acc_cyc: cyc + 1});
            end
        end
    end

    task automatic send(input logic [3:0] q, input logic [3:0] d, input logic [3:0] r,
                        output int acc_edge);
        Quotient  = q;
        Divisor   = d;
        Remainder = r;
        in_valid  = 1'b1;
        acc_edge  = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_edge = cyc + 1;
                break;
            end
        end
        if (acc_edge < 0) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic recv(input bit stall, output logic [7:0] div, output logic err,
                        output int seen);
        seen = -1;
        for (int i = 0; i < 300; i++) begin
            out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (out_valid && seen < 0) seen = cyc;
            if (out_valid && out_ready) begin
                div = Dividend;
                err = Error;
                @(posedge clk);
                #1 out_ready = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("result_timeout", 0, 1);
        div       = 'x;
        err       = 1'bx;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] q, input logic [3:0] d, input logic [3:0] r,
                          input int ediv, input bit eerr);
        int          a;
        int          s;
        logic [7:0]  dv;
        logic        er;
        send(q, d, r, a);
        recv(1'b0, dv, er, s);
        check($sformatf("dividend q=%0d d=%0d r=%0d", q, d, r), dv, ediv);
        check($sformatf("error q=%0d d=%0d r=%0d", q, d, r), er, eerr);
        check($sformatf("latency q=%0d d=%0d r=%0d", q, d, r), s - a + 1, eerr ? 1 : WIDTH + 1);
    endtask

    int tq[8]   = '{4, 2, 3, 15, 5, 0, 1, 0};
    int td[8]   = '{2, 3, 4, 15, 0, 0, 3, 7};
    int tr[8]   = '{0, 1, 3, 14, 3, 9, 3, 5};
    int tdiv[8] = '{8, 7, 15, 239, 0, 0, 0, 5};
    bit terr[8] = '{0, 0, 0, 0, 1, 1, 1, 0};

    initial begin
        int          a;
        int          s;
        logic [7:0]  dv;
        logic        er;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++)
            run_op(4'(tq[i]), 4'(td[i]), 4'(tr[i]), tdiv[i], terr[i]);

        // Backpressure: result must hold while new operands are offered and ignored.
        send(4'd6, 4'd9, 4'd4, a);
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b1;
            Quotient  = 4'($urandom());
            Divisor   = 4'($urandom());
            Remainder = 4'($urandom());
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_dividend", Dividend, 58);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        recv(1'b0, dv, er, s);
        check("bp_released_dividend", dv, 58);
        run_op(4'd3, 4'd5, 4'd1, 16, 1'b0);

        // Abort two cycles into the calculation.
        send(4'd9, 4'd11, 4'd3, a);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_no_valid", out_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_dividend", Dividend, 0);
        check("abort_error", Error, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_quiet", out_valid, 0);
        end
        @(posedge clk);
        #1;
        run_op(4'd7, 4'd5, 4'd2, 37, 1'b0);

        for (int q = 0; q < 16; q++)
            for (int d = 0; d < 16; d++)
                for (int r = 0; r < 16; r++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(4'(q), 4'(d), 4'(r), a);
                    recv(1'b1, dv, er, s);
                    check("sweep_dividend", dv, model_div(q, d, r));
                    check("sweep_error", er, model_err(q, d, r));
                end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
